// File: rtl/stepper_xy_scheduler.sv
// Two-axis move sequencer: accepts one X/Y move command, triggers the two
// stepper controllers, waits for both to finish, idles a settle interval and
// then pulses done. An armed axis that never reports working raises a sticky
// error and returns the scheduler to IDLE.
module stepper_xy_scheduler #(
  parameter int STEP_W       = 16,
  parameter int SETTLE_TICKS = 4,
  parameter int ARM_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_x_steps,
  input  logic              cmd_x_dir,
  input  logic [STEP_W-1:0] cmd_y_steps,
  input  logic              cmd_y_dir,
  output logic              x_trigger,
  output logic [STEP_W-1:0] x_steps,
  output logic              x_dir,
  input  logic              x_working,
  output logic              y_trigger,
  output logic [STEP_W-1:0] y_steps,
  output logic              y_dir,
  input  logic              y_working,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, SETTLE} state_t;

  state_t          state, state_n;
  logic            started_x, started_y;
  logic [SW-1:0]   settle_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            accept, zero_cmd, armed_x, armed_y, go_run, tmo_hit, settle_hit, axes_idle;

  // An axis with a zero count is never armed and never needs to start.
  assign armed_x    = (x_steps != '0);
  assign armed_y    = (y_steps != '0);
  // Working seen this cycle counts as started, so RUN is entered without an extra cycle.
  assign go_run     = (!armed_x || started_x || x_working) && (!armed_y || started_y || y_working);
  assign tmo_hit    = clk_en && (tmo_cnt <= TW'(1));
  assign settle_hit = clk_en && (settle_cnt <= SW'(1));
  assign axes_idle  = !x_working && !y_working;
  assign zero_cmd   = (cmd_x_steps == '0) && (cmd_y_steps == '0);
  assign accept     = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_n = zero_cmd ? SETTLE : ARM;
      end
      ARM: begin
        if (go_run)       state_n = RUN;
        else if (tmo_hit) state_n = IDLE;
      end
      RUN:     if (axes_idle) state_n = SETTLE;
      SETTLE:  if (settle_hit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command latch, triggers, start flags, counters and done/error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_steps    <= '0;
      y_steps    <= '0;
      x_dir      <= 1'b0;
      y_dir      <= 1'b0;
      x_trigger  <= 1'b0;
      y_trigger  <= 1'b0;
      started_x  <= 1'b0;
      started_y  <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          x_steps    <= cmd_x_steps;
          y_steps    <= cmd_y_steps;
          x_dir      <= cmd_x_dir;
          y_dir      <= cmd_y_dir;
          x_trigger  <= (cmd_x_steps != '0);
          y_trigger  <= (cmd_y_steps != '0);
          started_x  <= 1'b0;
          started_y  <= 1'b0;
          error      <= 1'b0;
          tmo_cnt    <= TW'(ARM_TIMEOUT);
          settle_cnt <= SW'(SETTLE_TICKS);
        end
        ARM: begin
          if (x_working) started_x <= 1'b1;
          if (y_working) started_y <= 1'b1;
          // Held across non-tick cycles; drops the cycle after working is seen.
          x_trigger <= armed_x && !(started_x || x_working);
          y_trigger <= armed_y && !(started_y || y_working);
          if (!go_run) begin
            if (tmo_hit) begin
              error     <= 1'b1;
              x_trigger <= 1'b0;
              y_trigger <= 1'b0;
            end else if (clk_en) begin
              tmo_cnt <= tmo_cnt - TW'(1);
            end
          end
        end
        RUN: begin
          x_trigger <= 1'b0;
          y_trigger <= 1'b0;
          if (axes_idle) settle_cnt <= SW'(SETTLE_TICKS);
        end
        SETTLE: if (clk_en) begin
          if (settle_cnt <= SW'(1)) done <= 1'b1;
          else                      settle_cnt <= settle_cnt - SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
